sdcard_cpu_bridge: RTL

// CPU-side master for the SD-card subsystem's four-phase async port. Converts one synchronous

---
 rtl/sdcard_cpu_bridge_if.sv | 46 ++++
 rtl/sdcard_cpu_bridge.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sdcard_cpu_bridge_if.sv
// Bundle of the CPU-side request/response port and the four-phase async port of sdcard_cpu_bridge.
// Modport master is the bridge's view; slave is the view of the CPU and the async responder.
interface sdcard_cpu_bridge_if #(
  parameter int ADDR = 32,
  parameter int DATA = 32,
  parameter int CMD  = 1
);
  logic            req_valid;
  logic            req_ready;
  logic [ADDR-1:0] req_addr;
  logic [CMD-1:0]  req_cmd;
  logic [DATA-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [DATA-1:0] resp_rdata;
  logic            resp_err;
  logic            busy;
  logic            async_addr_req;
  logic            async_addr_ack;
  logic [ADDR-1:0] async_addr;
  logic            async_cmd_req;
  logic            async_cmd_ack;
  logic [CMD-1:0]  async_cmd;
  logic            async_data_out_req;
  logic            async_data_out_ack;
  logic [DATA-1:0] async_data_out;
  logic            async_data_in_req;
  logic            async_data_in_ack;
  logic [DATA-1:0] async_data_in;

  modport master (
    input  req_valid, req_addr, req_cmd, req_wdata, resp_ready,
    input  async_addr_ack, async_cmd_ack, async_data_out_ack, async_data_in_req, async_data_in,
    output req_ready, resp_valid, resp_rdata, resp_err, busy,
    output async_addr_req, async_addr, async_cmd_req, async_cmd,
    output async_data_out_req, async_data_out, async_data_in_ack
  );

  modport slave (
    output req_valid, req_addr, req_cmd, req_wdata, resp_ready,
    output async_addr_ack, async_cmd_ack, async_data_out_ack, async_data_in_req, async_data_in,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy,
    input  async_addr_req, async_addr, async_cmd_req, async_cmd,
    input  async_data_out_req, async_data_out, async_data_in_ack
  );
endinterface

// File: rtl/sdcard_cpu_bridge.sv
// CPU-side master for the SD-card four-phase async port: one sync request -> addr/cmd/data handshakes.
// Optional wait-state watchdog enabled by defining SDCARD_BRIDGE_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | ready for a request (waits for all acks low when watchdog built)
// AC_REQ  | addr_req and cmd_req raised, waiting for both acks
// AC_REL  | reqs dropped, waiting for both acks to return to zero
// WR_REQ  | data_out_req raised, waiting for ack
// WR_REL  | data_out_req dropped, waiting for ack low
// RD_WAIT | waiting for responder's data_in_req; captures read data
// RD_REL  | data_in_ack held until data_in_req returns low
// RESP    | response presented until resp_ready
module sdcard_cpu_bridge #(
  parameter int ADDR    = 32,
  parameter int DATA    = 32,
  parameter int CMD     = 1,
  parameter int SYNC    = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic                clock,
  input  logic                reset,
  sdcard_cpu_bridge_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_AC_REQ, S_AC_REL, S_WR_REQ, S_WR_REL, S_RD_WAIT, S_RD_REL, S_RESP
  } state_t;

  localparam logic [15:0] TO_LOAD = 16'(TIMEOUT);

  state_t state_q, state_d;

  logic [SYNC-1:0] addr_ack_sync, cmd_ack_sync, dout_ack_sync, din_req_sync;
  logic            addr_ack_s, cmd_ack_s, dout_ack_s, din_req_s;
  logic            acks_low, idle_ok, accept, timeout;
  logic [ADDR-1:0] addr_q;
  logic [CMD-1:0]  cmd_q;
  logic [DATA-1:0] wdata_q;
  logic [DATA-1:0] rdata_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_ack_sync <= '0;
      cmd_ack_sync  <= '0;
      dout_ack_sync <= '0;
      din_req_sync  <= '0;
    end else begin
      addr_ack_sync <= {addr_ack_sync[SYNC-2:0], bus.async_addr_ack};
      cmd_ack_sync  <= {cmd_ack_sync[SYNC-2:0],  bus.async_cmd_ack};
      dout_ack_sync <= {dout_ack_sync[SYNC-2:0], bus.async_data_out_ack};
      din_req_sync  <= {din_req_sync[SYNC-2:0],  bus.async_data_in_req};
    end
  end

  assign addr_ack_s = addr_ack_sync[SYNC-1];
  assign cmd_ack_s  = cmd_ack_sync[SYNC-1];
  assign dout_ack_s = dout_ack_sync[SYNC-1];
  assign din_req_s  = din_req_sync[SYNC-1];
  assign acks_low   = !addr_ack_s && !cmd_ack_s && !dout_ack_s;

`ifdef SDCARD_BRIDGE_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        wait_state;

  assign wait_state = (state_q != S_IDLE) && (state_q != S_RESP);

  // Down-counter reloads on every state change; terminal count means TIMEOUT cycles in one state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                           to_cnt <= TO_LOAD;
    else if (state_d != state_q)          to_cnt <= TO_LOAD;
    else if (wait_state && to_cnt != '0)  to_cnt <= to_cnt - 16'd1;
  end

  assign timeout = wait_state && (to_cnt == 16'd0);
  // After an abort the responder may still hold an ack; never restart into a live handshake.
  assign idle_ok = acks_low;
`else
  logic unused_timeout;
  assign unused_timeout = ^{TO_LOAD, acks_low};
  assign timeout = 1'b0;
  assign idle_ok = 1'b1;
`endif

  assign accept = (state_q == S_IDLE) && idle_ok && bus.req_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = S_RESP;
    end else begin
      case (state_q)
        S_IDLE:    if (accept)                   state_d = S_AC_REQ;
        S_AC_REQ:  if (addr_ack_s && cmd_ack_s)  state_d = S_AC_REL;
        S_AC_REL:  if (!addr_ack_s && !cmd_ack_s)
                     state_d = cmd_q[0] ? S_WR_REQ : S_RD_WAIT;
        S_WR_REQ:  if (dout_ack_s)               state_d = S_WR_REL;
        S_WR_REL:  if (!dout_ack_s)              state_d = S_RESP;
        S_RD_WAIT: if (din_req_s)                state_d = S_RD_REL;
        S_RD_REL:  if (!din_req_s)               state_d = S_RESP;
        S_RESP:    if (bus.resp_ready)           state_d = S_IDLE;
        default:                                 state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.req_ready          = (state_q == S_IDLE) && idle_ok;
    bus.busy               = (state_q != S_IDLE);
    bus.async_addr_req     = (state_q == S_AC_REQ);
    bus.async_cmd_req      = (state_q == S_AC_REQ);
    bus.async_data_out_req = (state_q == S_WR_REQ);
    bus.async_data_in_ack  = (state_q == S_RD_REL);
    bus.resp_valid         = (state_q == S_RESP);
  end

  // Request buses are bundled data: held from accept until the bridge is idle again.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      cmd_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= bus.req_addr;
      cmd_q   <= bus.req_cmd;
      wdata_q <= bus.req_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                     rdata_q <= '0;
    else if (accept || timeout)                     rdata_q <= '0;
    else if ((state_q == S_RD_WAIT) && din_req_s)   rdata_q <= bus.async_data_in;
  end

`ifdef SDCARD_BRIDGE_TIMEOUT_EN
  logic err_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                       err_q <= 1'b0;
    else if (timeout)                                 err_q <= 1'b1;
    else if ((state_q == S_RESP) && bus.resp_ready)   err_q <= 1'b0;
  end
  assign bus.resp_err = err_q;
`else
  assign bus.resp_err = 1'b0;
`endif

  assign bus.async_addr     = addr_q;
  assign bus.async_cmd      = cmd_q;
  assign bus.async_data_out = wdata_q;
  assign bus.resp_rdata     = rdata_q;

endmodule
